alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Front-end controller that sequences the project ALU from a byte-serial command stream arriving on the 8-bit dedicated inputs. It collects opcode and operand bytes through a valid/ready handshake and drives the ALU operand/opcode registers. It waits the ALU's fixed latency, captures result and flags, and returns them through a second valid/ready handshake. An internal accumulator allows chained operations without reloading operand A.

Parameters:
WIDTH, 8, operand/result width in bits
ALU_LATENCY, 1, cycles from ALU inputs valid to result valid (min 1; 1 = combinational ALU)
NUM_OPS, 8, count of legal opcodes; opcode values >= NUM_OPS are illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
in_valid  in  1  command byte present on in_data
in_ready  out  1  sequencer accepts in_data this cycle
in_data  in  8  command byte stream
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_data  out  WIDTH  captured ALU result
out_flags  out  3  {err, zero, carry}
alu_op  out  4  opcode to ALU
alu_a  out  WIDTH  operand A to ALU
alu_b  out  WIDTH  operand B to ALU
alu_result  in  WIDTH  ALU result
alu_carry  in  1  ALU carry/borrow out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: the one clock, clk; reset is synchronous and active-high (port rst). On rst, state=IDLE. in_ready=0, out_valid=0, out_data=0, out_flags=0, alu_op=0, alu_a=0, alu_b=0, accumulator=0, busy=0. rst mid-operation discards all partial commands and pending results; no response is produced.
- Command format: byte0 = opcode. Bits[3:0] = op (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 PASS_A). Bit4 = use_acc. Bits[7:5] are reserved and ignored. Byte1 = A, omitted when use_acc=1. Byte2 = B.
- Transfer occurs on a cycle with in_valid&&in_ready. out transfer occurs on a cycle with out_valid&&out_ready.
- FSM states:
  - IDLE: in_ready=1. On transfer, latch op and use_acc. If op>=NUM_OPS, go to RESP with err=1, out_data=0, and the ALU is not driven. Else if use_acc, go to LOAD_B. Else go to LOAD_A.
  - LOAD_A: in_ready=1. On transfer, latch A and go to LOAD_B.
  - LOAD_B: in_ready=1. On transfer, latch B and go to EXEC. When use_acc=1, A=accumulator.
  - EXEC: in_ready=0. alu_op/alu_a/alu_b are registered and stable throughout EXEC. A counter runs ALU_LATENCY cycles. In the last EXEC cycle, sample alu_result/alu_carry into out_data/carry. Set zero=(alu_result==0) and load accumulator with alu_result. Go to RESP.
  - RESP: out_valid=1, in_ready=0. out_data/out_flags are held stable until transfer. On transfer, go to IDLE.
- Latency: B accepted in cycle T means the ALU inputs are valid from T+1 and out_valid rises at T+1+ALU_LATENCY.
- in_ready is never high while out_valid is high; there is one command in flight.
- alu_* outputs hold their last values outside EXEC. They change only on entry to EXEC.
- An illegal opcode leaves the accumulator unchanged and returns flags {1,0,0}.
- in_valid deasserted mid-command: the FSM waits in its LOAD state indefinitely.
- Accumulator wraps modulo 2^WIDTH, with no saturation.

Decomposition:
- Shared package alu_pkg holds: opcode enum (ADD..PASS_A), NUM_OPS, the opcode-byte bit positions (OP_MSB=3, USE_ACC_BIT=4), the flag bit indices (FLAG_CARRY=0, FLAG_ZERO=1, FLAG_ERR=2), and the FSM state typedef.
- One natural sub-module, alu_latency_counter, handles the EXEC wait. It has load and done signals and is sized by clog2(ALU_LATENCY+1).

Test Plan:
- Bytes 0x00, 0x12, 0x34 with out_ready=1 -> alu_op=0, alu_a=0x12, alu_b=0x34. One response out_data=0x46, out_flags=3'b000, out_valid at T+2 for ALU_LATENCY=1.
- ADD 0xFF, 0x01 -> out_data=0x00, out_flags=3'b011. Then 0x11 (SUB, use_acc), 0x01 -> alu_a=0x00, out_data=0xFF, carry per ALU borrow, zero=0.
- Opcode byte 0x0C -> response with no operand bytes consumed: out_data=0x00, out_flags=3'b100, accumulator unchanged, alu_* not updated.
- out_ready held 0 for 5 cycles after a result -> out_valid stays 1, out_data stable, in_ready=0 throughout. Next command is accepted only after the transfer.
- in_valid gaps of 3 cycles between bytes -> same result as back-to-back. busy=1 from first byte until the response transfer.
- rst=1 for one cycle while in LOAD_B and again during EXEC (ALU_LATENCY=3) -> all outputs return to reset values next cycle, no out_valid pulse, and the next command behaves normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU front-end sequencer.
//   - ALU opcode enumeration and the count of legal opcodes
//   - bit positions inside the command opcode byte
//   - bit indices of the {err, zero, carry} result flags
//   - sequencer FSM state type
package alu_pkg;

    localparam int unsigned NUM_OPS     = 8;

    // Opcode byte layout: [3:0] op, [4] use_acc, [7:5] reserved
    localparam int unsigned OP_MSB      = 3;
    localparam int unsigned USE_ACC_BIT = 4;

    // Result flag indices within out_flags
    localparam int unsigned FLAG_CARRY  = 0;
    localparam int unsigned FLAG_ZERO   = 1;
    localparam int unsigned FLAG_ERR    = 2;
    localparam int unsigned FLAG_W      = 3;

    typedef enum logic [OP_MSB:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SHL1   = 4'd5,
        OP_SHR1   = 4'd6,
        OP_PASS_A = 4'd7
    } alu_opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_RESP   = 3'd4
    } seq_state_e;

    // An opcode is legal when it falls below the configured opcode count.
    function automatic logic op_is_legal(input logic [OP_MSB:0] op,
                                         input int unsigned num_ops);
        return 32'(op) < num_ops;
    endfunction

endpackage

// File: rtl/alu_latency_counter.sv
// alu_latency_counter: times the ALU latency window of the EXEC state.
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset
//   load  in  preset the counter to LATENCY (on entry to EXEC)
//   en    in  count down while the sequencer sits in EXEC
//   done  out high during the last EXEC cycle
module alu_latency_counter #(
    parameter int unsigned LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(LATENCY);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // cnt == 1 marks the final cycle of the window, so EXEC lasts LATENCY cycles.
    always_comb begin
        done = en && (cnt == CNT_W'(1));
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: byte-serial command front end for the project ALU.
// Collects opcode / A / B bytes over a valid/ready input, drives registered
// ALU operands for ALU_LATENCY cycles, captures result and flags, and returns
// them over a valid/ready output. An accumulator (last result) may replace A.
//   clk, rst            clock / synchronous active-high reset
//   in_valid/in_ready   command byte handshake, in_data = byte
//   out_valid/out_ready result handshake, out_data / out_flags {err,zero,carry}
//   alu_op/alu_a/alu_b  registered ALU inputs, alu_result/alu_carry ALU outputs
//   busy                high whenever the FSM is not IDLE
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned NUM_OPS     = alu_pkg::NUM_OPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic [3:0]        alu_op,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_carry,
    output logic              busy
);

    seq_state_e state;
    seq_state_e state_nxt;

    logic [OP_MSB:0]    op_q;
    logic               use_acc_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   acc;

    logic               in_fire;
    logic               out_fire;
    logic [OP_MSB:0]    cmd_op;
    logic               cmd_use_acc;
    logic               cmd_legal;
    logic               exec_load;
    logic               exec_en;
    logic               exec_done;
    logic [FLAG_W-1:0]  res_flags;
    logic [FLAG_W-1:0]  err_flags;

    always_comb begin
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
        cmd_op      = in_data[OP_MSB:0];
        cmd_use_acc = in_data[USE_ACC_BIT];
        cmd_legal   = op_is_legal(cmd_op, NUM_OPS);
        exec_load   = (state == ST_LOAD_B) && in_fire;
        exec_en     = (state == ST_EXEC);
    end

    always_comb begin
        res_flags             = '0;
        res_flags[FLAG_CARRY] = alu_carry;
        res_flags[FLAG_ZERO]  = (alu_result == '0);
        err_flags             = '0;
        err_flags[FLAG_ERR]   = 1'b1;
    end

    alu_latency_counter #(
        .LATENCY (ALU_LATENCY)
    ) u_latency (
        .clk  (clk),
        .rst  (rst),
        .load (exec_load),
        .en   (exec_en),
        .done (exec_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_fire) begin
                    if (!cmd_legal) begin
                        state_nxt = ST_RESP;
                    end else if (cmd_use_acc) begin
                        state_nxt = ST_LOAD_B;
                    end else begin
                        state_nxt = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: if (in_fire)   state_nxt = ST_LOAD_B;
            ST_LOAD_B: if (in_fire)   state_nxt = ST_EXEC;
            ST_EXEC:   if (exec_done) state_nxt = ST_RESP;
            ST_RESP:   if (out_fire)  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs are gated by rst so they read as reset values during
    // the reset cycle itself, not only after it.
    always_comb begin
        in_ready  = !rst && ((state == ST_IDLE) || (state == ST_LOAD_A) ||
                             (state == ST_LOAD_B));
        out_valid = !rst && (state == ST_RESP);
        busy      = !rst && (state != ST_IDLE);
    end

    // Datapath: command latches, ALU operand registers, result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            use_acc_q <= 1'b0;
            a_q       <= '0;
            acc       <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            out_data  <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        op_q      <= cmd_op;
                        use_acc_q <= cmd_use_acc;
                        if (!cmd_legal) begin
                            out_data  <= '0;
                            out_flags <= err_flags;
                        end
                    end
                end
                ST_LOAD_A: begin
                    if (in_fire) a_q <= WIDTH'(in_data);
                end
                ST_LOAD_B: begin
                    if (in_fire) begin
                        alu_op <= op_q;
                        alu_a  <= use_acc_q ? acc : a_q;
                        alu_b  <= WIDTH'(in_data);
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        out_data  <= alu_result;
                        out_flags <= res_flags;
                        acc       <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
